// File: rtl/game_pkg.sv
// Key codes shared by the keyboard front end, the game state machine and player logic,
// plus the serial receiver state encoding and the ASCII-to-key map.
package game_pkg;

  localparam logic [3:0] KEY_NONE    = 4'b0000;
  localparam logic [3:0] KEY_UP      = 4'b0001;
  localparam logic [3:0] KEY_DOWN    = 4'b0010;
  localparam logic [3:0] KEY_LEFT    = 4'b0011;
  localparam logic [3:0] KEY_RIGHT   = 4'b0100;
  localparam logic [3:0] KEY_CONFIRM = 4'b0101;
  localparam logic [3:0] KEY_CANCEL  = 4'b0110;

  // RX_BREAK holds off re-triggering while the line sits low after a bad stop bit.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rxState_e;

  function automatic logic [3:0] mapKey(input logic [7:0] rxChar);
    case (rxChar)
      8'h77, 8'h57: mapKey = KEY_UP;       // w W
      8'h73, 8'h53: mapKey = KEY_DOWN;     // s S
      8'h61, 8'h41: mapKey = KEY_LEFT;     // a A
      8'h64, 8'h44: mapKey = KEY_RIGHT;    // d D
      8'h0D, 8'h20: mapKey = KEY_CONFIRM;  // CR, space
      8'h78, 8'h58: mapKey = KEY_CANCEL;   // x X
      default:      mapKey = KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: 2-flop synchroniser, mid-bit sampling FSM, one-clock byteValid
// and frameErr strobes.
module uart_rx_core
  import game_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       byteValid,
  output logic       frameErr
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  logic          rxMeta, rxSync;
  rxState_e      state, stateNext;
  logic [CW-1:0] baudCnt, baudCntNext;
  logic [2:0]    bitCnt, bitCntNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          byteValidNext, frameErrNext;

  // NOTE: synchroniser flops reset to 1 (line idle) so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
    end
  end

  // NOTE: state registers use non-blocking assignments only; all next values come from the comb block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RX_IDLE;
      baudCnt   <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      state     <= stateNext;
      baudCnt   <= baudCntNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      byteValid <= byteValidNext;
      frameErr  <= frameErrNext;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    stateNext     = state;
    baudCntNext   = baudCnt;
    bitCntNext    = bitCnt;
    shiftNext     = shiftReg;
    byteValidNext = 1'b0;
    frameErrNext  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (!rxSync) begin
          stateNext   = RX_START;
          baudCntNext = '0;
        end
      end
      RX_START: begin
        if (baudCnt == HALF_LAST) begin
          baudCntNext = '0;
          bitCntNext  = '0;
          stateNext   = rxSync ? RX_IDLE : RX_DATA;
        end else begin
          baudCntNext = baudCnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (baudCnt == BIT_LAST) begin
          baudCntNext = '0;
          shiftNext   = {rxSync, shiftReg[7:1]};
          if (bitCnt == 3'd7) stateNext = RX_STOP;
          else                bitCntNext = bitCnt + 3'd1;
        end else begin
          baudCntNext = baudCnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (baudCnt == BIT_LAST) begin
          baudCntNext = '0;
          if (rxSync) begin
            byteValidNext = 1'b1;
            stateNext     = RX_IDLE;
          end else begin
            frameErrNext = 1'b1;
            stateNext    = RX_BREAK;
          end
        end else begin
          baudCntNext = baudCnt + CW'(1);
        end
      end
      RX_BREAK: begin
        if (rxSync) stateNext = RX_IDLE;
      end
      default: stateNext = RX_IDLE;
    endcase
  end

  assign rxData = shiftReg;

endmodule

// File: rtl/uart_key_decoder.sv
// Serial keyboard front end: receives bytes, maps game keys to 4-bit codes and
// stretches each code to HOLD_CYCLES clocks on the keyboard port.
module uart_key_decoder
  import game_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] keyboard,
  output logic       keyValid,
  output logic [7:0] rxByte,
  output logic       frameErr
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  logic [7:0]    rxData;
  logic          byteValid;
  logic [3:0]    keyCode;
  logic [HW-1:0] holdCnt;

  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) rxCore (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rxData   (rxData),
    .byteValid(byteValid),
    .frameErr (frameErr)
  );

  assign keyCode = mapKey(rxData);

  // A new mapped key restarts the pulse; unmapped bytes leave a running pulse alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keyboard <= KEY_NONE;
      holdCnt  <= '0;
      rxByte   <= '0;
    end else begin
      if (byteValid) rxByte <= rxData;
      if (byteValid && keyCode != KEY_NONE) begin
        keyboard <= keyCode;
        holdCnt  <= HOLD_LOAD;
      end else if (holdCnt != '0) begin
        holdCnt <= holdCnt - HW'(1);
        if (holdCnt == HW'(1)) keyboard <= KEY_NONE;
      end
    end
  end

  assign keyValid = (keyboard != KEY_NONE);

endmodule
